// File: rtl/multiword_adder_pkg.sv
// Shared definitions for the multi-word adder: datapath word width and the sequencer state encoding.
package multiword_adder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/CLA_32bit.sv
// 32-bit carry-lookahead adder: full lookahead inside each 4-bit group, group carries ripple upward.
module CLA_32bit
  import multiword_adder_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < WORD_W; i += 4) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      c[i+2] = g[i+1] | (p[i+1] & g[i]) | (p[i+1] & p[i] & c[i]);
      c[i+3] = g[i+2] | (p[i+2] & g[i+1]) | (p[i+2] & p[i+1] & g[i])
             | (p[i+2] & p[i+1] & p[i] & c[i]);
      c[i+4] = g[i+3] | (p[i+3] & g[i+2]) | (p[i+3] & p[i+2] & g[i+1])
             | (p[i+3] & p[i+2] & p[i+1] & g[i])
             | (p[i+3] & p[i+2] & p[i+1] & p[i] & c[i]);
    end
    sum  = p ^ c[WORD_W-1:0];
    cout = c[WORD_W];
  end

endmodule

// File: rtl/multiword_adder.sv
// Wide unsigned adder: streams WORDS 32-bit words through one CLA, LSW first, with a registered carry.
module multiword_adder
  import multiword_adder_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                    cout
);

  localparam int                 IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int                 TOT_W    = WORD_W * WORDS;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [TOT_W-1:0]   a_q, a_d;
  logic [TOT_W-1:0]   b_q, b_d;
  logic [TOT_W-1:0]   sum_q, sum_d;

  logic [WORD_W-1:0]  cla_a;
  logic [WORD_W-1:0]  cla_b;
  logic [WORD_W-1:0]  cla_sum;
  logic               cla_cout;

  assign cla_a = a_q[WORD_W*int'(idx_q) +: WORD_W];
  assign cla_b = b_q[WORD_W*int'(idx_q) +: WORD_W];

  CLA_32bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[WORD_W*int'(idx_q) +: WORD_W] = cla_sum;
        carry_d = cla_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = cla_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      sum_q   <= sum_d;
    end
  end

  // Operand registers only load on acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
